a2d_arbiter: RTL
================

Name: a2d_arbiter

Overview:
Shares the single A2D SPI converter interface among NUM_REQ independent requesters: the slide-pot scanner, volume, battery/aux monitors. Each requester posts a channel and a request. The arbiter picks one requester round-robin, issues strt_cnv/chnnl to the A2D interface, and waits for cnv_cmplt. It then returns the 12-bit result with a done pulse to the owner. Only one conversion is in flight at a time, and a watchdog recovers from a missing cnv_cmplt.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT, 4096, max cycles in WAIT before abort (power of 2, >=16)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
req  in  NUM_REQ  per-requester conversion request (level)
req_chnnl  in  3*NUM_REQ  flattened channel per requester; slice i = [3i+2:3i]
gnt  out  NUM_REQ  one-hot one-cycle pulse: request accepted
done  out  NUM_REQ  one-hot one-cycle pulse: result (or abort) for owner
rd_data  out  12  last conversion result; held between deliveries
err  out  1  one-cycle pulse coincident with done on timeout abort
busy  out  1  high whenever state != IDLE
strt_cnv  out  1  one-cycle start pulse to A2D interface
chnnl  out  3  channel to A2D interface; held from START through DELIVER
cnv_cmplt  in  1  conversion complete from A2D interface (pulse or level)
res  in  12  conversion result from A2D interface

Behaviour:
- Reset values (async): state=IDLE, all outputs 0, rd_data=0, rr pointer=0, owner=0, timeout counter=0.
- States: IDLE, START, WAIT, DELIVER. All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.
- IDLE:
  - If req != 0, select the first set bit at or after the rr pointer, wrapping modulo NUM_REQ.
  - Latch owner and req_chnnl[owner] into chnnl, then go to START.
  - Otherwise stay in IDLE.
- START (exactly 1 cycle):
  - strt_cnv=1 and gnt[owner]=1.
  - Clear the timeout counter, then go to WAIT.
- WAIT:
  - cnv_cmplt is ignored on the first WAIT cycle (blanking for a stale level from the previous conversion).
  - From the second cycle on, cnv_cmplt=1 latches rd_data<=res and goes to DELIVER.
  - The counter increments each WAIT cycle. On reaching TIMEOUT-1 without cnv_cmplt, go to DELIVER with an abort flag set; rd_data is unchanged.
  - If cnv_cmplt and the timeout occur in the same cycle, cnv_cmplt wins (normal completion).
- DELIVER (1 cycle):
  - done[owner]=1; err=abort flag.
  - rr pointer <= (owner+1) mod NUM_REQ; go to IDLE.
- cnv_cmplt is ignored in IDLE, START and DELIVER.
- Latency:
  - req sampled in IDLE at cycle N → gnt/strt_cnv at N+1.
  - cnv_cmplt at cycle M → done and rd_data valid at M+1.
  - Next arbitration at M+2; the minimum gap between strt_cnv pulses is 4 cycles plus conversion time.
- Requester rules:
  - req_chnnl must be stable while req is high.
  - The requester deasserts req the cycle after gnt. If req is still high in the IDLE that follows DELIVER, it is treated as a new request, at lowest priority because of the pointer advance.
  - Deasserting req after gnt does not cancel the conversion.
- Fairness: with all requesters continuously active, grants rotate 0,1,…,NUM_REQ-1,0; no requester waits more than NUM_REQ-1 conversions.
- Reset mid-operation: immediate return to IDLE. No done or err pulse is generated for the aborted owner; strt_cnv and chnnl go to 0.

Decomposition:
- Package a2d_arb_pkg contains:
  - state enum {IDLE, START, WAIT, DELIVER}
  - CHNL_W=3, RES_W=12
  - the channel constants CH_LP=0, CH_B1=1, CH_B2=2, CH_B3=3, CH_HP=4, CH_VOL=7
- Sub-module a2d_rr_pick: combinational round-robin picker. Inputs: req vector and pointer. Outputs: owner index and a valid flag. It is parameterised by NUM_REQ.
- The top level holds the FSM, the latches, the timeout counter and the pointer.

Test Plan:
1. After reset, req[2]=1 with ch=5; cnv_cmplt pulses 20 cycles after strt_cnv with res=0xABC → gnt=4'b0100 and strt_cnv one cycle after req with chnnl=5; done=4'b0100 one cycle after cnv_cmplt; rd_data=0xABC; err=0.
2. All four req held high after reset, channels 0,1,2,7, each conversion 10 cycles → grant order 0,1,2,3,0,1; chnnl sequence 0,1,2,7,0,1.
3. req[1]=1 with cnv_cmplt never asserted → done[1] and err pulse exactly TIMEOUT cycles after entering WAIT; rd_data retains the prior value; a pending req[3] is then granted.
4. rst_n asserted low midway through WAIT → on the same edge all outputs are 0 and state is IDLE; no done pulse appears after release.
5. cnv_cmplt held high through IDLE, START and the first WAIT cycle, then low, then pulsed with res=0x123 → completion occurs only on the later pulse, with rd_data=0x123.
6. cnv_cmplt and timeout coincide on the terminal count with res=0x0FF → done without err; rd_data=0x0FF.

Source files
------------

// File: rtl/a2d_arb_pkg.sv
// a2d_arb_pkg: shared FSM state type, widths and A2D channel numbers for the arbiter
package a2d_arb_pkg;
   typedef enum logic [1:0] {IDLE, START, WAIT, DELIVER} state_t;
   localparam int CHNL_W = 3;
   localparam int RES_W  = 12;
   localparam logic [CHNL_W-1:0] CH_LP  = 3'd0;
   localparam logic [CHNL_W-1:0] CH_B1  = 3'd1;
   localparam logic [CHNL_W-1:0] CH_B2  = 3'd2;
   localparam logic [CHNL_W-1:0] CH_B3  = 3'd3;
   localparam logic [CHNL_W-1:0] CH_HP  = 3'd4;
   localparam logic [CHNL_W-1:0] CH_VOL = 3'd7;
endpackage

// File: rtl/a2d_rr_pick.sv
// a2d_rr_pick: combinational round-robin picker, first request at or after ptr_i
module a2d_rr_pick #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
   output logic [$clog2(NUM_REQ)-1:0] owner_o,
   output logic                       valid_o
);
   localparam int IDX_W = $clog2(NUM_REQ);
   logic [IDX_W-1:0] idx;
   // Walk from farthest to nearest so the closest request after ptr_i wins.
   always_comb begin
      owner_o = '0;
      valid_o = 1'b0;
      idx     = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
         if (req_i[idx]) begin
            owner_o = idx;
            valid_o = 1'b1;
         end
      end
   end
endmodule

// File: rtl/a2d_arbiter.sv
// a2d_arbiter: round-robin sharing of one A2D converter among NUM_REQ requesters with timeout recovery
module a2d_arbiter
   import a2d_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 4096
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [CHNL_W*NUM_REQ-1:0] req_chnnl,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        done,
   output logic [RES_W-1:0]          rd_data,
   output logic                      err,
   output logic                      busy,
   output logic                      strt_cnv,
   output logic [CHNL_W-1:0]         chnnl,
   input  logic                      cnv_cmplt,
   input  logic [RES_W-1:0]          res
);
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT);
   state_t             state_q;
   logic [IDX_W-1:0]   owner_q, ptr_q, pick_idx;
   logic [CNT_W-1:0]   cnt_q;
   logic               abort_q, pick_vld;
   logic [CHNL_W-1:0]  chnnl_q;
   logic [RES_W-1:0]   rd_data_q;
   logic [NUM_REQ-1:0] own_oh;
   logic [CHNL_W-1:0]  chn [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_chn
      assign chn[i] = req_chnnl[CHNL_W*i +: CHNL_W];
   end

   a2d_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .owner_o (pick_idx),
      .valid_o (pick_vld)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         owner_q   <= '0;
         ptr_q     <= '0;
         cnt_q     <= '0;
         abort_q   <= 1'b0;
         chnnl_q   <= '0;
         rd_data_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (pick_vld) begin
               owner_q <= pick_idx;
               chnnl_q <= chn[pick_idx];
               state_q <= START;
            end
            START: begin
               cnt_q   <= '0;
               abort_q <= 1'b0;
               state_q <= WAIT;
            end
            // cnt_q == 0 marks the first WAIT cycle, where a stale cnv_cmplt level is blanked.
            WAIT: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnv_cmplt && cnt_q != '0) begin
                  rd_data_q <= res;
                  state_q   <= DELIVER;
               end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  abort_q <= 1'b1;
                  state_q <= DELIVER;
               end
            end
            DELIVER: begin
               ptr_q   <= (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign own_oh   = NUM_REQ'(1) << owner_q;
   assign gnt      = (state_q == START) ? own_oh : '0;
   assign done     = (state_q == DELIVER) ? own_oh : '0;
   assign err      = (state_q == DELIVER) && abort_q;
   assign strt_cnv = state_q == START;
   assign busy     = state_q != IDLE;
   assign chnnl    = chnnl_q;
   assign rd_data  = rd_data_q;
endmodule
